vram_arbiter: RTL
=================

# vram_arbiter

Shares the single video-RAM port between the single-cycle CPU and the display refresh path. CPU VRAM accesses (`rvram`/`wvram` from the CPU's C0000000–DFFFFFFF window) always win, because the CPU cannot stall. The display side issues a line-fetch request, and the block streams words from VRAM into a small prefetch FIFO in every cycle the CPU leaves the port idle. It sits between the CPU, the VRAM macro and the VGA scan-out logic.

## Interface
- `VRAM_AW`, 13: VRAM word-address width; VRAM holds 2^VRAM_AW 32-bit words.
- `FIFO_AW`, 2: FIFO depth is 2^FIFO_AW entries (must be ≥1).
- `clk` in 1: clock; all state updates on its rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `cpu_addr` in 32: CPU byte address (`m_addr`); word address is bits [VRAM_AW+1:2].
- `cpu_wdata` in 32: CPU store data.
- `cpu_wvram` in 1: CPU VRAM write this cycle.
- `cpu_rvram` in 1: CPU VRAM read this cycle.
- `cpu_rdata` out 32: VRAM read data to CPU; equals `vram_rdata`.
- `vram_addr` out VRAM_AW: VRAM word address.
- `vram_wdata` out 32: VRAM write data, equals `cpu_wdata`.
- `vram_we` out 1: VRAM write enable, equals `cpu_wvram`.
- `vram_rdata` in 32: VRAM combinational (asynchronous) read data.
- `disp_req` in 1: start line fetch; sampled only in IDLE.
- `disp_base` in VRAM_AW: first word address of the fetch.
- `disp_len` in VRAM_AW+1: number of words to fetch (0..2^VRAM_AW).
- `disp_abort` in 1: cancel the fetch and flush the FIFO.
- `disp_pop` in 1: consume the FIFO head.
- `disp_data` out 32: FIFO head (show-ahead); 0 when empty.
- `disp_empty` out 1: FIFO empty.
- `fetch_busy` out 1: high in FETCH.
- `fetch_done` out 1: one-cycle pulse when the last word of a fetch is written to the FIFO.
- `disp_underrun` out 1: sticky flag; `disp_pop` was asserted while the FIFO was empty.

## Operation
- Port mux: `cpu_act = cpu_wvram | cpu_rvram`.
  - When `cpu_act` is high, `vram_addr` = CPU word address.
  - Otherwise `vram_addr` = fetch address.
  - The CPU is never delayed. Its reads and writes complete in the same cycle.
- States: IDLE, FETCH.
- IDLE, on `disp_req`:
  - Latch `fa` = `disp_base` and `rem` = `disp_len`.
  - Clear `disp_underrun`.
  - If `disp_len` = 0, pulse `fetch_done` next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH, issue rule: a fetch is issued in a cycle when `!cpu_act` and the FIFO is not full at the start of the cycle. A pop in the same cycle does not free space for that cycle.
- FETCH, on issue:
  - Push `vram_rdata` into the FIFO.
  - `fa` ← `fa`+1, modulo 2^VRAM_AW (wraps from all-ones to 0).
  - `rem` ← `rem`−1.
- FETCH, completion: on the issue that makes `rem` = 0, go to IDLE and assert `fetch_done` in the following cycle.
- `disp_req` during FETCH is ignored.
- `disp_abort`:
  - In any state, go to IDLE, empty the FIFO and clear `rem`.
  - No `fetch_done` pulse.
  - Abort overrides an issue or pop in the same cycle.
  - Abort in IDLE with a simultaneous `disp_req`: the abort wins and the request is dropped.
- FIFO:
  - `disp_pop` on a non-empty FIFO advances the head.
  - `disp_pop` on an empty FIFO is ignored and sets `disp_underrun`.
  - A simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged.
  - A push into an empty FIFO with a simultaneous pop: the pop is an underrun and the push is stored.
- Pointers: `FIFO_AW`-bit read and write pointers plus a `FIFO_AW+1`-bit count; pointers wrap naturally.

## Timing
- Reset values (`clr` high): state IDLE; `fa`, `rem`, pointers and count 0; `disp_empty`=1, `disp_data`=0, `fetch_busy`=0, `fetch_done`=0, `disp_underrun`=0.
- `vram_we`, `vram_wdata` and `cpu_rdata` follow their inputs combinationally, also during reset.
- Latency, with the CPU idle: `disp_req` high at edge N → FETCH from N; first issue in cycle N..N+1 → `disp_empty` low after edge N+1.
- Fetch throughput: 1 word per cycle, minus CPU-occupied cycles and FIFO-full cycles.
- `fetch_busy` is registered: high in the cycles after acceptance, through the cycle of the last issue.
- A `clr` assertion mid-fetch returns to the reset state immediately; no `fetch_done` pulse.

## Test plan
- **Basic fetch:** VRAM[k]=k+0x100; with the CPU idle, `disp_req`, base 5, len 3, popping every cycle → `disp_data` 0x105, 0x106, 0x107; `fetch_done` pulses once; `disp_underrun`=0.
- **CPU priority:** `cpu_wvram` asserted during 2 of the fetch cycles at addr 0xC0000010 → VRAM[4] is written; `vram_addr`=4 in those cycles; the fetch resumes with no skipped or duplicated word.
- **FIFO full:** FIFO_AW=2, len 6, no pops → 4 words are stored, then issuing stops with `fetch_busy` high; 2 pops → the remaining 2 words are fetched and `fetch_done` pulses.
- **Wrap-around:** base 0x1FFE, len 4 → the words come from addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001, in that order.
- **Abort / len 0 / underrun:**
  - `disp_abort` mid-fetch → FIFO empty next cycle and no `fetch_done`.
  - len 0 → `fetch_done` pulses with no push.
  - Pop on an empty FIFO → `disp_underrun`=1 until the next accepted `disp_req`.
- **Reset mid-fetch:** `clr` pulsed while in FETCH with 2 words buffered → all outputs return to their reset values; the next `disp_req` behaves as in the basic-fetch scenario.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU, VRAM macro and display-side signal bundle for vram_arbiter
interface vram_arbiter_if #(
  parameter int VRAM_AW = 13
);
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic               cpu_wvram;
  logic               cpu_rvram;
  logic [31:0]        cpu_rdata;
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_wdata;
  logic               vram_we;
  logic [31:0]        vram_rdata;
  logic               disp_req;
  logic [VRAM_AW-1:0] disp_base;
  logic [VRAM_AW:0]   disp_len;
  logic               disp_abort;
  logic               disp_pop;
  logic [31:0]        disp_data;
  logic               disp_empty;
  logic               fetch_busy;
  logic               fetch_done;
  logic               disp_underrun;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wvram, cpu_rvram, vram_rdata,
    input  disp_req, disp_base, disp_len, disp_abort, disp_pop,
    output cpu_rdata, vram_addr, vram_wdata, vram_we,
    output disp_data, disp_empty, fetch_busy, fetch_done, disp_underrun
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wvram, cpu_rvram, vram_rdata,
    output disp_req, disp_base, disp_len, disp_abort, disp_pop,
    input  cpu_rdata, vram_addr, vram_wdata, vram_we,
    input  disp_data, disp_empty, fetch_busy, fetch_done, disp_underrun
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port sharing between CPU (always wins) and display line prefetch FIFO
module vram_arbiter #(
  parameter int VRAM_AW = 13,
  parameter int FIFO_AW = 2
) (
  input logic           clk,
  input logic           clr,
  vram_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t             state, state_nx;
  logic [VRAM_AW-1:0] fa;
  logic [VRAM_AW:0]   rem;
  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   cnt;
  logic               cpu_act, fifo_full, fifo_empty;
  logic               accept, issue, last_issue, pop_ok;
  logic               busy_q, done_q, und_q;
  logic               unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.cpu_addr[31:VRAM_AW+2], bus.cpu_addr[1:0]};

  // CPU owns the port whenever it touches VRAM; fetches only use idle cycles
  assign cpu_act        = bus.cpu_wvram | bus.cpu_rvram;
  assign bus.vram_addr  = cpu_act ? bus.cpu_addr[VRAM_AW+1:2] : fa;
  assign bus.vram_wdata = bus.cpu_wdata;
  assign bus.vram_we    = bus.cpu_wvram;
  assign bus.cpu_rdata  = bus.vram_rdata;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);
  assign accept     = (state == S_IDLE) && bus.disp_req && !bus.disp_abort;
  assign issue      = (state == S_FETCH) && !cpu_act && !fifo_full && !bus.disp_abort;
  assign last_issue = issue && (rem == {{VRAM_AW{1'b0}}, 1'b1});
  assign pop_ok     = bus.disp_pop && !fifo_empty && !bus.disp_abort;

  always_comb begin
    state_nx = state;
    if (bus.disp_abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept && bus.disp_len != '0) state_nx = S_FETCH;
        S_FETCH: if (last_issue) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == S_FETCH);
      done_q <= (accept && bus.disp_len == '0) || last_issue;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fa  <= '0;
      rem <= '0;
    end else if (bus.disp_abort) begin
      rem <= '0;
    end else if (accept) begin
      fa  <= bus.disp_base;
      rem <= bus.disp_len;
    end else if (issue) begin
      fa  <= fa + 1'b1;
      rem <= rem - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (bus.disp_abort) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (issue)  wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      case ({issue, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fifo_mem[wp] <= bus.vram_rdata;
  end

  // A pop on an empty FIFO in the accepting cycle still counts as an underrun
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      und_q <= 1'b0;
    end else if (!bus.disp_abort) begin
      if (bus.disp_pop && fifo_empty) und_q <= 1'b1;
      else if (accept)                und_q <= 1'b0;
    end
  end

  assign bus.disp_data     = fifo_empty ? 32'h0 : fifo_mem[rp];
  assign bus.disp_empty    = fifo_empty;
  assign bus.fetch_busy    = busy_q;
  assign bus.fetch_done    = done_q;
  assign bus.disp_underrun = und_q;
endmodule
